// File: rtl/sram_like_ram_slave.sv
// sram_like_ram_slave: responder end of the sram-like handshake.
// Accepts one request at a time, holds it for a programmable number of
// cycles, then answers with a one-cycle data_ok strobe. Storage is a
// word-organised 32-bit RAM with byte-lane writes; upper address bits alias.
module sram_like_ram_slave #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2    // cycles from accept edge to data_ok cycle, 1..15
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic [31:0] txn_count
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t state;
  state_t state_next;

  // Latency down-counter; only meaningful while in ST_WAIT.
  logic [3:0] cnt;

  // Request captured at the handshake; later input changes are ignored.
  logic                  hwr;
  logic [1:0]            hsize;
  logic [ADDR_WIDTH+1:0] haddr;
  logic [31:0]           hwdata;

  logic [31:0] mem [DEPTH];

  logic                  handshake;
  logic [3:0]            byte_en;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  rd_is_wr;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  resp_entry;

  // Address bits above the RAM index are deliberately ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];

  assign handshake = req & addr_ok;
  assign word_idx  = haddr[ADDR_WIDTH+1:2];

  // With LATENCY == 1 the RESP entry edge is the accept edge itself, so the
  // RAM read must use the live request rather than the holding registers.
  assign rd_is_wr   = (state == ST_IDLE) ? wr : hwr;
  assign rd_idx     = (state == ST_IDLE) ? addr[ADDR_WIDTH+1:2] : word_idx;
  assign resp_entry = (state != ST_RESP) && (state_next == ST_RESP);

  // Next-state logic and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_next = state;
    addr_ok    = 1'b0;
    data_ok    = 1'b0;
    case (state)
      ST_IDLE: begin
        addr_ok = req & resetn;
        if (req) begin
          state_next = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd1) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        data_ok    = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Byte-lane enables derived from the captured size and low address bits.
  always_comb begin
    byte_en = 4'b0000;
    case (hsize)
      2'd0:    byte_en = 4'b0001 << haddr[1:0];
      2'd1:    byte_en = haddr[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  // State register, latency counter and request holding registers.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!resetn) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      hwr    <= 1'b0;
      hsize  <= 2'd0;
      haddr  <= '0;
      hwdata <= 32'd0;
    end else begin
      state <= state_next;
      if (handshake) begin
        hwr    <= wr;
        hsize  <= size;
        haddr  <= addr[ADDR_WIDTH+1:0];
        hwdata <= wdata;
        cnt    <= CNT_LOAD;
      end else if (state == ST_WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Registered read data, loaded on the edge that enters RESP for reads.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata <= 32'd0;
    end else if (resp_entry && !rd_is_wr) begin
      rdata <= mem[rd_idx];
    end
  end

  // Completed-transaction counter, bumped on the edge leaving RESP.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      txn_count <= 32'd0;
    end else if (state == ST_RESP) begin
      txn_count <= txn_count + 32'd1;
    end
  end

  // RAM write port: commits a write on the edge leaving RESP.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset so it maps onto block RAM; a reset
    // dropped mid-transaction never reaches RESP and so never commits.
    if (state == ST_RESP && hwr) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][8*b +: 8] <= hwdata[8*b +: 8];
        end
      end
    end
  end

endmodule
